// File: rtl/debounce_pkg.sv
// Shared helpers for the debouncer family.
// Provides clog2_min1() and the index/count widths for the default configuration.
package debounce_pkg;

  // Smallest w with 2**w >= n, never less than 1 (safe as a vector width)
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

  localparam int unsigned NUM_CH_DEF   = 4;
  localparam int unsigned DELAY_DEF    = 16;
  localparam int unsigned TICK_DIV_DEF = 1;
  localparam int unsigned IW = clog2_min1(NUM_CH_DEF);
  localparam int unsigned CW = clog2_min1(DELAY_DEF);

endpackage

// File: rtl/debounce_tick_gen.sv
// Scan-step prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
// Ports: clk, rst_n (async active-low), enable (freeze when 0), step_c (combinational step strobe).
module debounce_tick_gen
  import debounce_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic step_c
);

  localparam int unsigned PW = clog2_min1(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;

  // Prescaler counter, held while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (enable) begin
      pre <= (pre == LAST) ? '0 : pre + PW'(1);
    end
  end

  assign step_c = enable && (pre == LAST);

endmodule

// File: rtl/debounce_scan_scheduler.sv
// Time-multiplexed debouncer: one shared counter datapath serves NUM_CH inputs,
// visited round-robin one channel per scan step. Debounced edges are reported
// through a single-entry valid/ready event slot.
// Ports: clk, rst_n (async active-low), enable, din[NUM_CH] (raw),
//        dout[NUM_CH] (debounced), event_valid/event_ready/event_chan/event_level,
//        busy_stall (a commit is waiting for the event slot).
module debounce_scan_scheduler
  import debounce_pkg::*;
#(
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned DELAY    = 16,
  parameter  int unsigned TICK_DIV = 1,
  localparam int unsigned IW       = clog2_min1(NUM_CH),
  localparam int unsigned CW       = clog2_min1(DELAY)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] dout,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [IW-1:0]     event_chan,
  output logic              event_level,
  output logic              busy_stall
);

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [CW-1:0]     cnt [NUM_CH];
  logic [IW-1:0]     idx;

  logic          tick_c;
  logic          visit_c;
  logic          diff_c;
  logic          at_max_c;
  logic          slot_free_c;
  logic          commit_c;
  logic          blocked_c;
  logic          advance_c;
  logic [CW-1:0] cur_c;

  debounce_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .step_c(tick_c)
  );

  // Step decode for the channel under the scan index.
  // A stalled commit retries every cycle regardless of the prescaler.
  always_comb begin
    cur_c       = cnt[idx];
    visit_c     = enable & (tick_c | busy_stall);
    diff_c      = sync2[idx] ^ dout[idx];
    at_max_c    = (cur_c == CW'(DELAY - 1));
    slot_free_c = ~event_valid | event_ready;
    commit_c    = visit_c & diff_c & at_max_c & slot_free_c;
    blocked_c   = visit_c & diff_c & at_max_c & ~slot_free_c;
    advance_c   = visit_c & ~blocked_c;
  end

  // Synchronizers, count storage, scan index and event slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      dout        <= '0;
      idx         <= '0;
      busy_stall  <= 1'b0;
      event_valid <= 1'b0;
      event_chan  <= '0;
      event_level <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      sync1      <= din;
      sync2      <= sync1;
      busy_stall <= blocked_c;

      if (advance_c) begin
        idx <= (idx == IW'(NUM_CH - 1)) ? '0 : idx + IW'(1);
        if (!diff_c) begin
          cnt[idx] <= '0;
        end else if (!at_max_c) begin
          cnt[idx] <= cur_c + CW'(1);
        end else begin
          cnt[idx]  <= '0;
          dout[idx] <= ~dout[idx];
        end
      end

      // A commit may refill the slot in the same cycle the old event leaves
      if (commit_c) begin
        event_valid <= 1'b1;
        event_chan  <= idx;
        event_level <= ~dout[idx];
      end else if (event_valid && event_ready) begin
        event_valid <= 1'b0;
      end
    end
  end

endmodule
